mac_vert_col_sched: RTL and testbench



---
 rtl/mac_vert_col_sched.sv | 149 ++++++++++++++
 tb/tb_mac_vert_col_sched.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_vert_col_sched.sv
// mac_vert_col_sched
//   Column scheduler for the bit-serial vertical 32-lane MAC datapath.
//   Each tile walks the non-zero weight bit columns MSB-first, then flushes
//   the two-stage psum/accum pipeline and holds the result until accepted.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   start_valid/ready     tile request handshake; col_mask sampled on it
//   col_mask              bit c set -> weight column c must be issued
//   col_avail / col_fire  weight-column buffer present / consume strobe
//   en_acc, load_accum    MAC accumulate enable, accum_prev base select
//   column_idx, is_msb    shift amount of current column, sign column flag
//   flush_zero            MAC forces a zero psum contribution
//   busy                  scheduler is not idle
//   done_valid/ready      tile result handshake
//
// state  | meaning
// IDLE   | waiting for a tile, start_ready=1
// ISSUE  | issuing highest remaining mask column, stalls on !col_avail
// FLUSH0 | empty mask: zero contribution to fill the first pipeline stage
// FLUSH  | zero contribution, drains the psum/accum pipeline
// DONE   | result stable at MAC output, waits for done_ready

module mac_vert_col_sched #(
   parameter int NUM_COLS      = 8,
   parameter int COL_IDX_WIDTH = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start_valid,
   output logic                     start_ready,
   input  logic [NUM_COLS-1:0]      col_mask,
   input  logic                     col_avail,
   output logic                     col_fire,
   output logic                     en_acc,
   output logic                     load_accum,
   output logic [COL_IDX_WIDTH-1:0] column_idx,
   output logic                     is_msb,
   output logic                     flush_zero,
   output logic                     busy,
   output logic                     done_valid,
   input  logic                     done_ready
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ISSUE  = 3'd1;
   localparam logic [2:0] S_FLUSH0 = 3'd2;
   localparam logic [2:0] S_FLUSH  = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]               state_q;
   logic [2:0]               state_d;
   logic [NUM_COLS-1:0]      mask_q;
   logic [NUM_COLS-1:0]      mask_d;
   // first_q: one en_acc cycle already issued this tile.
   // lacc_done_q: load_accum already given this tile.
   logic                     first_q;
   logic                     lacc_done_q;
   logic [COL_IDX_WIDTH-1:0] top_idx;
   logic [NUM_COLS-1:0]      top_onehot;
   logic                     start_hs;

   // Priority encoder: the highest set bit wins since later iterations overwrite.
   always_comb begin
      top_idx = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
         if (mask_q[c]) top_idx = COL_IDX_WIDTH'(c);
      end
      top_onehot          = '0;
      top_onehot[top_idx] = 1'b1;
   end

   assign start_hs = (state_q == S_IDLE) && start_valid;

   always_comb begin
      start_ready = 1'b0;
      col_fire    = 1'b0;
      en_acc      = 1'b0;
      column_idx  = '0;
      is_msb      = 1'b0;
      flush_zero  = 1'b0;
      done_valid  = 1'b0;
      case (state_q)
         S_IDLE: start_ready = 1'b1;
         S_ISSUE: begin
            column_idx = top_idx;
            is_msb     = (top_idx == COL_IDX_WIDTH'(NUM_COLS - 1));
            en_acc     = col_avail;
            col_fire   = col_avail;
         end
         S_FLUSH0, S_FLUSH: begin
            en_acc     = 1'b1;
            flush_zero = 1'b1;
         end
         S_DONE: done_valid = 1'b1;
         default: ;
      endcase
   end

   // The MAC adds the previous shift-register value, which is stale on the
   // first en_acc cycle of a tile; the second en_acc cycle takes accum_prev.
   assign load_accum = en_acc && first_q && !lacc_done_q;
   assign busy       = (state_q != S_IDLE);

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      case (state_q)
         S_IDLE: begin
            if (start_valid) begin
               mask_d  = col_mask;
               state_d = (|col_mask) ? S_ISSUE : S_FLUSH0;
            end
         end
         S_ISSUE: begin
            if (col_avail) begin
               mask_d = mask_q & ~top_onehot;
               if (mask_d == '0) state_d = S_FLUSH;
            end
         end
         S_FLUSH0: state_d = S_FLUSH;
         S_FLUSH:  state_d = S_DONE;
         S_DONE: begin
            if (done_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         mask_q      <= '0;
         first_q     <= 1'b0;
         lacc_done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         if (start_hs) begin
            first_q     <= 1'b0;
            lacc_done_q <= 1'b0;
         end else if (en_acc) begin
            first_q <= 1'b1;
            if (first_q) lacc_done_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mac_vert_col_sched.sv
// tb_mac_vert_col_sched
//   Directed-vector bench for mac_vert_col_sched. Cycle n of a tile is the
//   n-th clock period after the start handshake edge; outputs are sampled on
//   the falling edge, inputs are driven 1 ns after the rising edge.

module tb_mac_vert_col_sched;

   logic       clk;
   logic       reset;
   logic       start_valid;
   logic       start_ready;
   logic [7:0] col_mask;
   logic       col_avail;
   logic       col_fire;
   logic       en_acc;
   logic       load_accum;
   logic [2:0] column_idx;
   logic       is_msb;
   logic       flush_zero;
   logic       busy;
   logic       done_valid;
   logic       done_ready;

   int n_checks = 0;
   int n_errors = 0;

   mac_vert_col_sched #(.NUM_COLS(8), .COL_IDX_WIDTH(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .col_mask    (col_mask),
      .col_avail   (col_avail),
      .col_fire    (col_fire),
      .en_acc      (en_acc),
      .load_accum  (load_accum),
      .column_idx  (column_idx),
      .is_msb      (is_msb),
      .flush_zero  (flush_zero),
      .busy        (busy),
      .done_valid  (done_valid),
      .done_ready  (done_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One tile cycle: drive col_avail, sample at the falling edge, advance.
   task automatic step(input string tag, input int n, input logic av,
                       input logic en, input logic fire, input logic [2:0] col,
                       input logic msb, input logic lacc, input logic fz,
                       input logic dv);
      col_avail = av;
      @(negedge clk);
      chk($sformatf("%s c%0d en_acc", tag, n),      32'(en_acc),      32'(en));
      chk($sformatf("%s c%0d col_fire", tag, n),    32'(col_fire),    32'(fire));
      chk($sformatf("%s c%0d column_idx", tag, n),  32'(column_idx),  32'(col));
      chk($sformatf("%s c%0d is_msb", tag, n),      32'(is_msb),      32'(msb));
      chk($sformatf("%s c%0d load_accum", tag, n),  32'(load_accum),  32'(lacc));
      chk($sformatf("%s c%0d flush_zero", tag, n),  32'(flush_zero),  32'(fz));
      chk($sformatf("%s c%0d done_valid", tag, n),  32'(done_valid),  32'(dv));
      chk($sformatf("%s c%0d busy", tag, n),        32'(busy),        32'(1));
      chk($sformatf("%s c%0d start_ready", tag, n), 32'(start_ready), 32'(0));
      @(posedge clk);
      #1;
   endtask

   // Handshake cycle T; afterwards col_mask is scrambled to prove it was latched.
   task automatic start_tile(input string tag, input logic [7:0] m);
      start_valid = 1'b1;
      col_mask    = m;
      @(negedge clk);
      chk({tag, " start_ready"}, 32'(start_ready), 32'(1));
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      col_mask    = ~m;
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk);
      chk({tag, " idle start_ready"}, 32'(start_ready), 32'(1));
      chk({tag, " idle busy"},        32'(busy),        32'(0));
      chk({tag, " idle done_valid"},  32'(done_valid),  32'(0));
      chk({tag, " idle en_acc"},      32'(en_acc),      32'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic full_mask_tile(input string tag);
      start_tile(tag, 8'hFF);
      for (int i = 1; i <= 8; i++)
         step(tag, i, 1'b1, 1'b1, 1'b1, 3'(8 - i), (i == 1), (i == 2), 1'b0, 1'b0);
      step(tag, 9,  1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(tag, 10, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle_check(tag);
   endtask

   initial begin
      reset       = 1'b1;
      start_valid = 1'b0;
      col_mask    = 8'h00;
      col_avail   = 1'b1;
      done_ready  = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst start_ready", 32'(start_ready), 32'(1));
      chk("rst busy",        32'(busy),        32'(0));
      chk("rst en_acc",      32'(en_acc),      32'(0));
      chk("rst col_fire",    32'(col_fire),    32'(0));
      chk("rst done_valid",  32'(done_valid),  32'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle_check("post_rst");

      full_mask_tile("full");

      // Columns 7 then 0.
      start_tile("sparse", 8'h81);
      step("sparse", 1, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      step("sparse", 2, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      step("sparse", 3, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step("sparse", 4, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle_check("sparse");

      // Empty mask: FLUSH0 then FLUSH carrying load_accum.
      start_tile("empty", 8'h00);
      step("empty", 1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step("empty", 2, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      step("empty", 3, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle_check("empty");

      // Single column: FLUSH carries load_accum.
      start_tile("single", 8'h04);
      step("single", 1, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      step("single", 2, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      step("single", 3, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle_check("single");

      // Two stall cycles while column 2 is pending: 4 issue + 2 stall cycles,
      // FLUSH at T+7 and done_valid at T+8.
      start_tile("stall", 8'h0F);
      step("stall", 1, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      step("stall", 2, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      step("stall", 3, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      step("stall", 4, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      step("stall", 5, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      step("stall", 6, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("stall", 7, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step("stall", 8, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle_check("stall");

      // Backpressure: done held 5 extra cycles with a new start pending.
      start_tile("bp", 8'h04);
      step("bp", 1, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      done_ready = 1'b0;
      step("bp", 2, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      start_valid = 1'b1;
      col_mask    = 8'h81;
      for (int i = 3; i <= 7; i++)
         step("bp", i, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      done_ready = 1'b1;
      step("bp", 8, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      // Next tile is accepted in the single IDLE cycle that follows.
      start_tile("bp_next", 8'h81);
      step("bp_next", 1, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      step("bp_next", 2, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      step("bp_next", 3, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step("bp_next", 4, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle_check("bp_next");

      // Reset while column 5 is being issued.
      start_tile("rst_mid", 8'hFF);
      step("rst_mid", 1, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      step("rst_mid", 2, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("rst_mid c3 column_idx", 32'(column_idx), 32'(5));
      #1;
      reset = 1'b1;
      #1;
      chk("rst_mid async en_acc",     32'(en_acc),     32'(0));
      chk("rst_mid async col_fire",   32'(col_fire),   32'(0));
      chk("rst_mid async column_idx", 32'(column_idx), 32'(0));
      chk("rst_mid async busy",       32'(busy),       32'(0));
      chk("rst_mid async load_accum", 32'(load_accum), 32'(0));
      chk("rst_mid async done_valid", 32'(done_valid), 32'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) idle_check("rst_mid");

      full_mask_tile("post_rst_full");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
